// File: rtl/uart_pkg.sv
// Shared constants, state encodings and parity helper for the wide UART transceiver.
package uart_pkg;

    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_EVEN = 2'd1;
    localparam logic [1:0] PARITY_ODD  = 2'd2;

    localparam logic [1:0] UART_ERR_NONE    = 2'd0;
    localparam logic [1:0] UART_ERR_FRAME   = 2'd1;
    localparam logic [1:0] UART_ERR_PARITY  = 2'd2;
    localparam logic [1:0] UART_ERR_TIMEOUT = 2'd3;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    // Parity bit that goes on the line for a data byte under the given mode.
    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
        logic p;
        p = ^data;
        case (mode)
            PARITY_ODD: parity_bit = ~p;
            default:    parity_bit = p;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one tick every max(divisor,1) clock cycles.
module uart_baud_tick (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] divisor,
    output logic        tick
);

    logic [15:0] cnt_r;
    logic [15:0] reload_s;

    // Reload value; 0 and 1 both give a tick every cycle.
    always_comb begin
        if (divisor > 16'd1) begin
            reload_s = divisor - 16'd1;
        end else begin
            reload_s = 16'd0;
        end
    end

    // Down-counter; a new divisor is picked up only at reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 16'd0;
        end else if (cnt_r == 16'd0) begin
            cnt_r <= reload_s;
        end else begin
            cnt_r <= cnt_r - 16'd1;
        end
    end

    assign tick = (cnt_r == 16'd0);

endmodule

// File: rtl/uart_wide_transceiver.sv
// Full-duplex UART moving DATA_BYTES-octet words, MSB byte first, with parity,
// stop-bit and inter-byte timeout handling on the receive side.
module uart_wide_transceiver
    import uart_pkg::*;
#(
    parameter int DATA_BYTES   = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [15:0]             divisor,
    input  logic                    uart_rx,
    output logic                    uart_tx,
    output logic [8*DATA_BYTES-1:0] rx_data,
    output logic                    rx_done,
    output logic                    rx_err,
    output logic [1:0]              rx_err_code,
    input  logic [8*DATA_BYTES-1:0] tx_data,
    input  logic                    tx_wr,
    output logic                    tx_ready,
    output logic                    tx_done
);

    localparam int W        = 8 * DATA_BYTES;
    localparam int BC_W     = $clog2(DATA_BYTES + 1);
    localparam int TO_TICKS = TIMEOUT_BITS * OVERSAMPLE;
    localparam int TO_W     = (TIMEOUT_BITS > 0) ? $clog2(TO_TICKS) : 1;
    localparam bit PAR_EN   = (PARITY != 0);
    localparam bit TO_EN    = (TIMEOUT_BITS > 0);
    localparam logic [1:0]      PAR_MODE  = 2'(PARITY);
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(DATA_BYTES - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TO_TICKS - 1);
    localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

    logic tick_s;

    uart_baud_tick u_tick (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .divisor (divisor),
        .tick    (tick_s)
    );

    logic rx_meta_r, rx_sync_r;

    // Two-flop synchroniser for the asynchronous serial input.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= uart_rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    rx_state_t        rx_state_r, rx_state_nxt;
    logic [3:0]       rx_ph_r, rx_ph_nxt;
    logic [2:0]       rx_bit_r, rx_bit_nxt;
    logic [7:0]       rx_byte_r, rx_byte_nxt;
    logic             rx_perr_r, rx_perr_nxt;
    logic [W-1:0]     rx_asm_r, rx_asm_nxt, rx_asm_shift_s;
    logic [BC_W-1:0]  rx_cnt_r, rx_cnt_nxt;
    logic [TO_W-1:0]  rx_to_r, rx_to_nxt;
    logic [W-1:0]     rx_data_r, rx_data_nxt;
    logic             rx_done_r, rx_done_nxt;
    logic             rx_err_r, rx_err_nxt;
    logic [1:0]       rx_code_r, rx_code_nxt;
    logic             rx_sample_s;

    assign rx_sample_s    = tick_s && (rx_ph_r == 4'd0);
    assign rx_asm_shift_s = (rx_asm_r << 8) | W'(rx_byte_r);

    // RX next-state: the phase counter wraps 0->15 so samples repeat every 16 ticks.
    always_comb begin
        rx_state_nxt = rx_state_r;
        rx_ph_nxt    = (tick_s && (rx_state_r != RX_IDLE)) ? (rx_ph_r - 4'd1) : rx_ph_r;
        rx_bit_nxt   = rx_bit_r;
        rx_byte_nxt  = rx_byte_r;
        rx_perr_nxt  = rx_perr_r;
        rx_asm_nxt   = rx_asm_r;
        rx_cnt_nxt   = rx_cnt_r;
        rx_to_nxt    = rx_to_r;
        rx_data_nxt  = rx_data_r;
        rx_code_nxt  = rx_code_r;
        rx_done_nxt  = 1'b0;
        rx_err_nxt   = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                if (tick_s && !rx_sync_r) begin
                    rx_state_nxt = RX_START;
                    rx_ph_nxt    = 4'd7;
                    rx_perr_nxt  = 1'b0;
                    rx_to_nxt    = {TO_W{1'b0}};
                end else if (tick_s && TO_EN && (rx_cnt_r != {BC_W{1'b0}})) begin
                    if (rx_to_r == TO_LAST) begin
                        rx_cnt_nxt  = {BC_W{1'b0}};
                        rx_to_nxt   = {TO_W{1'b0}};
                        rx_err_nxt  = 1'b1;
                        rx_code_nxt = UART_ERR_TIMEOUT;
                    end else begin
                        rx_to_nxt = rx_to_r + TO_W'(1);
                    end
                end else if (rx_cnt_r == {BC_W{1'b0}}) begin
                    rx_to_nxt = {TO_W{1'b0}};
                end else begin
                    rx_to_nxt = rx_to_r;
                end
            end
            RX_START: begin
                if (rx_sample_s) begin
                    rx_state_nxt = rx_sync_r ? RX_IDLE : RX_DATA;
                    rx_bit_nxt   = 3'd0;
                end else begin
                    rx_state_nxt = rx_state_r;
                end
            end
            RX_DATA: begin
                if (rx_sample_s) begin
                    rx_byte_nxt = {rx_sync_r, rx_byte_r[7:1]};
                    rx_bit_nxt  = rx_bit_r + 3'd1;
                    if (rx_bit_r == 3'd7) begin
                        rx_state_nxt = PAR_EN ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_state_nxt = RX_DATA;
                    end
                end else begin
                    rx_state_nxt = rx_state_r;
                end
            end
            RX_PARITY: begin
                if (rx_sample_s) begin
                    rx_perr_nxt  = (rx_sync_r != parity_bit(rx_byte_r, PAR_MODE));
                    rx_state_nxt = RX_STOP;
                end else begin
                    rx_state_nxt = rx_state_r;
                end
            end
            RX_STOP: begin
                if (rx_sample_s) begin
                    rx_state_nxt = RX_IDLE;
                    if (!rx_sync_r || rx_perr_r) begin
                        rx_err_nxt  = 1'b1;
                        rx_code_nxt = !rx_sync_r ? UART_ERR_FRAME : UART_ERR_PARITY;
                        rx_cnt_nxt  = {BC_W{1'b0}};
                    end else if (rx_cnt_r == LAST_BYTE) begin
                        rx_asm_nxt  = rx_asm_shift_s;
                        rx_data_nxt = rx_asm_shift_s;
                        rx_done_nxt = 1'b1;
                        rx_cnt_nxt  = {BC_W{1'b0}};
                    end else begin
                        rx_asm_nxt = rx_asm_shift_s;
                        rx_cnt_nxt = rx_cnt_r + BC_W'(1);
                    end
                end else begin
                    rx_state_nxt = rx_state_r;
                end
            end
            default: begin
                rx_state_nxt = RX_IDLE;
            end
        endcase
    end

    // RX state and datapath registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_state_r <= RX_IDLE;
            rx_ph_r    <= 4'd0;
            rx_bit_r   <= 3'd0;
            rx_byte_r  <= 8'd0;
            rx_perr_r  <= 1'b0;
            rx_asm_r   <= {W{1'b0}};
            rx_cnt_r   <= {BC_W{1'b0}};
            rx_to_r    <= {TO_W{1'b0}};
            rx_data_r  <= {W{1'b0}};
            rx_done_r  <= 1'b0;
            rx_err_r   <= 1'b0;
            rx_code_r  <= UART_ERR_NONE;
        end else begin
            rx_state_r <= rx_state_nxt;
            rx_ph_r    <= rx_ph_nxt;
            rx_bit_r   <= rx_bit_nxt;
            rx_byte_r  <= rx_byte_nxt;
            rx_perr_r  <= rx_perr_nxt;
            rx_asm_r   <= rx_asm_nxt;
            rx_cnt_r   <= rx_cnt_nxt;
            rx_to_r    <= rx_to_nxt;
            rx_data_r  <= rx_data_nxt;
            rx_done_r  <= rx_done_nxt;
            rx_err_r   <= rx_err_nxt;
            rx_code_r  <= rx_code_nxt;
        end
    end

    assign rx_data     = rx_data_r;
    assign rx_done     = rx_done_r;
    assign rx_err      = rx_err_r;
    assign rx_err_code = rx_code_r;

    tx_state_t        tx_state_r, tx_state_nxt;
    logic [W-1:0]     tx_shift_r, tx_shift_nxt;
    logic [3:0]       tx_ph_r, tx_ph_nxt;
    logic [2:0]       tx_bit_r, tx_bit_nxt;
    logic             tx_stop_r, tx_stop_nxt;
    logic [BC_W-1:0]  tx_cnt_r, tx_cnt_nxt;
    logic             tx_line_r, tx_line_nxt;
    logic             tx_ready_r, tx_ready_nxt;
    logic             tx_done_r, tx_done_nxt;
    logic [7:0]       tx_cur_s;
    logic             tx_bit_end_s;

    assign tx_cur_s     = tx_shift_r[W-1 -: 8];
    assign tx_bit_end_s = tick_s && (tx_ph_r == 4'd15);

    // TX next-state: the current byte always sits in the top octet of the shifter.
    always_comb begin
        tx_state_nxt = tx_state_r;
        tx_shift_nxt = tx_shift_r;
        tx_ph_nxt    = (tick_s && (tx_state_r != TX_IDLE)) ? (tx_ph_r + 4'd1) : tx_ph_r;
        tx_bit_nxt   = tx_bit_r;
        tx_stop_nxt  = tx_stop_r;
        tx_cnt_nxt   = tx_cnt_r;
        tx_line_nxt  = tx_line_r;
        tx_ready_nxt = tx_ready_r;
        tx_done_nxt  = 1'b0;
        case (tx_state_r)
            TX_IDLE: begin
                if (tx_wr && tx_ready_r) begin
                    tx_shift_nxt = tx_data;
                    tx_state_nxt = TX_START;
                    tx_ph_nxt    = 4'd0;
                    tx_cnt_nxt   = {BC_W{1'b0}};
                    tx_line_nxt  = 1'b0;
                    tx_ready_nxt = 1'b0;
                end else begin
                    tx_line_nxt  = 1'b1;
                    tx_ready_nxt = 1'b1;
                end
            end
            TX_START: begin
                if (tx_bit_end_s) begin
                    tx_state_nxt = TX_DATA;
                    tx_bit_nxt   = 3'd0;
                    tx_line_nxt  = tx_cur_s[0];
                end else begin
                    tx_state_nxt = tx_state_r;
                end
            end
            TX_DATA: begin
                if (tx_bit_end_s && (tx_bit_r == 3'd7)) begin
                    tx_state_nxt = PAR_EN ? TX_PARITY : TX_STOP;
                    tx_line_nxt  = PAR_EN ? parity_bit(tx_cur_s, PAR_MODE) : 1'b1;
                    tx_stop_nxt  = 1'b0;
                end else if (tx_bit_end_s) begin
                    tx_bit_nxt  = tx_bit_r + 3'd1;
                    tx_line_nxt = tx_cur_s[tx_bit_r + 3'd1];
                end else begin
                    tx_state_nxt = tx_state_r;
                end
            end
            TX_PARITY: begin
                if (tx_bit_end_s) begin
                    tx_state_nxt = TX_STOP;
                    tx_line_nxt  = 1'b1;
                    tx_stop_nxt  = 1'b0;
                end else begin
                    tx_state_nxt = tx_state_r;
                end
            end
            TX_STOP: begin
                if (tx_bit_end_s && (tx_stop_r != STOP_LAST)) begin
                    tx_stop_nxt = 1'b1;
                end else if (tx_bit_end_s && (tx_cnt_r == LAST_BYTE)) begin
                    tx_state_nxt = TX_IDLE;
                    tx_line_nxt  = 1'b1;
                    tx_ready_nxt = 1'b1;
                    tx_done_nxt  = 1'b1;
                end else if (tx_bit_end_s) begin
                    tx_state_nxt = TX_START;
                    tx_shift_nxt = tx_shift_r << 8;
                    tx_cnt_nxt   = tx_cnt_r + BC_W'(1);
                    tx_line_nxt  = 1'b0;
                end else begin
                    tx_state_nxt = tx_state_r;
                end
            end
            default: begin
                tx_state_nxt = TX_IDLE;
                tx_line_nxt  = 1'b1;
                tx_ready_nxt = 1'b1;
            end
        endcase
    end

    // TX state and datapath registers; the line idles high out of reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_state_r <= TX_IDLE;
            tx_shift_r <= {W{1'b0}};
            tx_ph_r    <= 4'd0;
            tx_bit_r   <= 3'd0;
            tx_stop_r  <= 1'b0;
            tx_cnt_r   <= {BC_W{1'b0}};
            tx_line_r  <= 1'b1;
            tx_ready_r <= 1'b1;
            tx_done_r  <= 1'b0;
        end else begin
            tx_state_r <= tx_state_nxt;
            tx_shift_r <= tx_shift_nxt;
            tx_ph_r    <= tx_ph_nxt;
            tx_bit_r   <= tx_bit_nxt;
            tx_stop_r  <= tx_stop_nxt;
            tx_cnt_r   <= tx_cnt_nxt;
            tx_line_r  <= tx_line_nxt;
            tx_ready_r <= tx_ready_nxt;
            tx_done_r  <= tx_done_nxt;
        end
    end

    assign uart_tx  = tx_line_r;
    assign tx_ready = tx_ready_r;
    assign tx_done  = tx_done_r;

endmodule

// File: tb/tb_uart_wide_transceiver.sv
// Directed bench: a loopback instance (no parity) for TX/RX words and reset abort,
// and a parity/timeout instance driven by a bench-side serial generator.
module tb_uart_wide_transceiver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] divisor = 16'd2;

    always #5 clk = ~clk;

    logic        tx0, rx_done0, rx_err0, tx_ready0, tx_done0;
    logic        tx_wr0 = 1'b0;
    logic [31:0] rx_data0;
    logic [31:0] tx_data0 = 32'h0;
    logic [1:0]  code0;

    uart_wide_transceiver #(.DATA_BYTES(4), .PARITY(0), .STOP_BITS(1), .TIMEOUT_BITS(32)) u_dut (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .divisor     (divisor),
        .uart_rx     (tx0),
        .uart_tx     (tx0),
        .rx_data     (rx_data0),
        .rx_done     (rx_done0),
        .rx_err      (rx_err0),
        .rx_err_code (code0),
        .tx_data     (tx_data0),
        .tx_wr       (tx_wr0),
        .tx_ready    (tx_ready0),
        .tx_done     (tx_done0)
    );

    logic        line1 = 1'b1;
    logic        tx1, rx_done1, rx_err1, tx_ready1, tx_done1;
    logic [31:0] rx_data1;
    logic [31:0] tx_data1 = 32'h0;
    logic        tx_wr1 = 1'b0;
    logic [1:0]  code1;

    uart_wide_transceiver #(.DATA_BYTES(4), .PARITY(1), .STOP_BITS(1), .TIMEOUT_BITS(4)) u_dut_par (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .divisor     (divisor),
        .uart_rx     (line1),
        .uart_tx     (tx1),
        .rx_data     (rx_data1),
        .rx_done     (rx_done1),
        .rx_err      (rx_err1),
        .rx_err_code (code1),
        .tx_data     (tx_data1),
        .tx_wr       (tx_wr1),
        .tx_ready    (tx_ready1),
        .tx_done     (tx_done1)
    );

    int cyc = 0;
    int n_total = 0;
    int n_bad = 0;
    int done0_n = 0, err0_n = 0, txd0_n = 0, done1_n = 0, err1_n = 0;
    int t_b[4];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_done0 === 1'b1) done0_n <= done0_n + 1;
        if (rx_err0  === 1'b1) err0_n  <= err0_n + 1;
        if (tx_done0 === 1'b1) txd0_n  <= txd0_n + 1;
        if (rx_done1 === 1'b1) done1_n <= done1_n + 1;
        if (rx_err1  === 1'b1) err1_n  <= err1_n + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic decode_byte(output logic [7:0] b, output int t, output logic stop_v);
        int k = 0;
        b = 8'h00;
        while (tx0 !== 1'b0 && k < 2000) begin
            step(1);
            k++;
        end
        check_eq("start_seen", {63'd0, tx0 === 1'b0}, 64'd1);
        t = cyc;
        step(16);
        for (int i = 0; i < 8; i++) begin
            step(32);
            b[i] = tx0;
        end
        step(32);
        stop_v = tx0;
    endtask

    task automatic decode_word(output logic [31:0] w);
        logic [7:0] b;
        logic       s;
        int         t;
        w = 32'h0;
        for (int j = 0; j < 4; j++) begin
            decode_byte(b, t, s);
            w = {w[23:0], b};
            t_b[j] = t;
            check_eq("stop_bit", {63'd0, s}, 64'd1);
        end
    endtask

    task automatic wait_tx_done(output int td);
        int k = 0;
        while (tx_done0 !== 1'b1 && k < 400) begin
            step(1);
            k++;
        end
        check_eq("tx_done_seen", {63'd0, tx_done0 === 1'b1}, 64'd1);
        td = cyc;
    endtask

    task automatic bit_time(input logic v);
        line1 = v;
        repeat (32) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop_v);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time((^b) ^ bad_par);
        bit_time(stop_v);
        bit_time(1'b1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_frame(w[8*i +: 8], 1'b0, 1'b1);
    endtask

    initial begin
        logic [31:0] w;
        int td, d, base_td, base_rd, base_re, base_d1, base_e1;
        logic saw_low;

        step(5);
        check_eq("rst_uart_tx", tx0, 1);
        check_eq("rst_tx_ready", tx_ready0, 1);
        check_eq("rst_tx_done", tx_done0, 0);
        check_eq("rst_rx_done", rx_done0, 0);
        check_eq("rst_rx_err", rx_err0, 0);
        check_eq("rst_rx_err_code", code0, 0);
        check_eq("rst_rx_data", rx_data0, 0);
        check_eq("rst_par_rx_data", rx_data1, 0);
        rst_n = 1'b1;
        step(3);

        // Word transmit with loopback receive.
        base_td = txd0_n; base_rd = done0_n; base_re = err0_n;
        tx_data0 = 32'hDEADBEEF;
        tx_wr0 = 1'b1;
        check_eq("idle_before_accept", tx0, 1);
        step(1);
        tx_wr0 = 1'b0;
        check_eq("start_after_accept", tx0, 0);
        check_eq("ready_drops", tx_ready0, 0);
        decode_word(w);
        check_eq("tx_word", w, 32'hDEADBEEF);
        d = t_b[1] - t_b[0];
        check_eq("first_byte_len", {63'd0, (d >= 319 && d <= 320)}, 64'd1);
        check_eq("byte2_len", t_b[2] - t_b[1], 320);
        check_eq("byte3_len", t_b[3] - t_b[2], 320);
        wait_tx_done(td);
        check_eq("tx_done_time", td - t_b[3], 320);
        check_eq("ready_with_done", tx_ready0, 1);
        step(200);
        check_eq("tx_done_count", txd0_n - base_td, 1);
        check_eq("loop_rx_done_count", done0_n - base_rd, 1);
        check_eq("loop_rx_data", rx_data0, 32'hDEADBEEF);
        check_eq("loop_rx_err_count", err0_n - base_re, 0);

        // Write while busy is ignored.
        base_rd = done0_n;
        tx_data0 = 32'h11223344;
        tx_wr0 = 1'b1;
        step(1);
        tx_wr0 = 1'b0;
        fork
            decode_word(w);
            begin
                step(50);
                tx_data0 = 32'h55667788;
                tx_wr0 = 1'b1;
                step(1);
                tx_wr0 = 1'b0;
                check_eq("busy_ready_low", tx_ready0, 0);
            end
        join
        check_eq("busy_tx_word", w, 32'h11223344);
        check_eq("ready_low_before_done", tx_ready0, 0);
        wait_tx_done(td);
        check_eq("busy_ready_at_done", tx_ready0, 1);
        saw_low = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step(1);
            if (tx0 === 1'b0) saw_low = 1'b1;
        end
        check_eq("no_second_word", saw_low, 0);
        check_eq("busy_rx_data", rx_data0, 32'h11223344);
        check_eq("busy_rx_done_count", done0_n - base_rd, 1);

        // Parity error, then a clean word.
        base_d1 = done1_n; base_e1 = err1_n;
        send_frame(8'h01, 1'b1, 1'b1);
        check_eq("par_err_count", err1_n - base_e1, 1);
        check_eq("par_err_code", code1, 2);
        send_word(32'h01020304);
        check_eq("par_after_rx_data", rx_data1, 32'h01020304);
        check_eq("par_after_done_count", done1_n - base_d1, 1);
        check_eq("par_after_err_count", err1_n - base_e1, 1);

        // Framing error on byte 2 drops the partial word.
        base_d1 = done1_n; base_e1 = err1_n;
        send_frame(8'hA1, 1'b0, 1'b1);
        send_frame(8'hB2, 1'b0, 1'b0);
        check_eq("frame_err_count", err1_n - base_e1, 1);
        check_eq("frame_err_code", code1, 1);
        send_word(32'h10203040);
        check_eq("frame_after_rx_data", rx_data1, 32'h10203040);
        check_eq("frame_after_done_count", done1_n - base_d1, 1);
        check_eq("frame_after_err_count", err1_n - base_e1, 1);

        // Inter-byte timeout.
        base_d1 = done1_n; base_e1 = err1_n;
        send_frame(8'h55, 1'b0, 1'b1);
        send_frame(8'h66, 1'b0, 1'b1);
        check_eq("to_no_early_err", err1_n - base_e1, 0);
        step(400);
        check_eq("to_err_count", err1_n - base_e1, 1);
        check_eq("to_err_code", code1, 3);
        check_eq("to_no_done", done1_n - base_d1, 0);
        send_word(32'hAABBCCDD);
        check_eq("to_after_rx_data", rx_data1, 32'hAABBCCDD);
        check_eq("to_after_done_count", done1_n - base_d1, 1);

        // Reset in the middle of byte 3 aborts the word.
        base_td = txd0_n; base_rd = done0_n;
        tx_data0 = 32'hCAFEF00D;
        tx_wr0 = 1'b1;
        step(1);
        tx_wr0 = 1'b0;
        step(2 * 320 + 100);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_uart_tx", tx0, 1);
        check_eq("midrst_tx_ready", tx_ready0, 1);
        check_eq("midrst_rx_data", rx_data0, 0);
        step(5);
        rst_n = 1'b1;
        step(400);
        check_eq("midrst_no_tx_done", txd0_n - base_td, 0);
        check_eq("midrst_no_rx_done", done0_n - base_rd, 0);
        tx_data0 = 32'h0BADC0DE;
        tx_wr0 = 1'b1;
        step(1);
        tx_wr0 = 1'b0;
        decode_word(w);
        check_eq("post_rst_tx_word", w, 32'h0BADC0DE);
        wait_tx_done(td);
        step(200);
        check_eq("post_rst_rx_data", rx_data0, 32'h0BADC0DE);
        check_eq("post_rst_rx_done_count", done0_n - base_rd, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
